set_mode_controller: RTL and testbench
======================================

SET_MODE_CONTROLLER -- requirements
Module: set_mode_controller

Interface
REQ-001 Parameter REPEAT_DLY, default 50000000: clk cycles a held up/down button waits before auto-repeat starts (0.5 s at 100 MHz).
REQ-002 Parameter REPEAT_PER, default 25000000: clk cycles between auto-repeat pulses (4 Hz at 100 MHz).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_prog  input  1  debounced level; toggles set mode.
REQ-006 btn_left  input  1  debounced level; selects previous field.
REQ-007 btn_right  input  1  debounced level; selects next field.
REQ-008 btn_up  input  1  debounced level; increments the selected field.
REQ-009 btn_down  input  1  debounced level; decrements the selected field.
REQ-010 wr_ack  input  1  RTC write-back acknowledge, one or more cycles.
REQ-011 en_count  output  4  field select: 0 none, 1 seconds, 2 minutes, 3 hours, 4 year, 5 month, 6 day.
REQ-012 enUP  output  1  one-cycle increment pulse to the selected field counter.
REQ-013 enDOWN  output  1  one-cycle decrement pulse to the selected field counter.
REQ-014 wr_req  output  1  write-back request, level, held until acknowledged.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 All button inputs shall be registered once; "edge" means registered-now 1 and registered-previous 0.
REQ-017 The FSM shall have exactly the states IDLE, EDIT and WRITE.
REQ-018 In IDLE: en_count=0, enUP=enDOWN=0; a btn_prog edge moves to EDIT with en_count=1.
REQ-019 In EDIT: a btn_right edge advances en_count 1->2->...->6->1; a btn_left edge reverses it, 1->6.
REQ-020 In EDIT: simultaneous btn_left and btn_right edges shall leave en_count unchanged.
REQ-021 In EDIT: a btn_up edge shall drive enUP=1 for exactly one cycle, one cycle after the registered edge; btn_down does the same for enDOWN.
REQ-022 Auto-repeat: while exactly one of up/down stays held, the next pulse comes REPEAT_DLY cycles after the first pulse, then one every REPEAT_PER cycles.
REQ-023 The repeat counter shall be wide enough for max(REPEAT_DLY, REPEAT_PER), shall never wrap, and shall clear on release.
REQ-024 With both up and down held, the block shall issue no pulses and hold the repeat counter at 0; repeat restarts from the edge rule once only one is held.
REQ-025 A field change (left/right edge) shall clear the repeat counter, so a held up/down waits REPEAT_DLY again.
REQ-026 enUP and enDOWN shall never be high in the same cycle and shall be 0 outside EDIT.
REQ-027 In EDIT: a btn_prog edge moves to WRITE; that cycle's up/down pulse is suppressed.
REQ-028 In WRITE: en_count=0 and wr_req=1; when wr_ack is sampled 1, next cycle wr_req=0 and state=IDLE.
REQ-029 In WRITE: all buttons including btn_prog shall be ignored.
REQ-030 An edge present on the cycle of a state change shall be consumed by that change and not reused in the new state.

Reset
REQ-031 While reset=1: state=IDLE; en_count=0; enUP=enDOWN=wr_req=busy=0; repeat counter=0; button registers=0.
REQ-032 Reset asserted mid-EDIT or mid-WRITE shall abort immediately with no write-back; a button already held at release shall not count as an edge until re-pressed.

Verification
REQ-033 Reset, btn_prog pulse -> busy=1, en_count=1; 7 btn_right pulses -> en_count 2,3,4,5,6,1,2.
REQ-034 EDIT, en_count=4, btn_up held 0.5 s + 3 periods (REPEAT_DLY=20, REPEAT_PER=5) -> enUP pulses at +1, +21, +26, +31 cycles; release -> no more pulses.
REQ-035 btn_up and btn_down held together -> zero pulses; release btn_down -> enUP pulse after REPEAT_DLY measured from the counter restart.
REQ-036 btn_prog in EDIT -> en_count=0, wr_req=1 held; wr_ack after 10 cycles -> wr_req=0, busy=0 next cycle.
REQ-037 Reset asserted during WRITE with wr_req=1 -> all outputs 0 at once; btn_prog held through release -> stays IDLE.
REQ-038 btn_left and btn_right edges in the same cycle at en_count=3 -> en_count stays 3.

Source files
------------

// File: rtl/set_mode_controller.sv
// Set-mode controller: walks the RTC fields for editing and issues up/down pulses.
// Held up/down buttons auto-repeat, and the edited time is handed back through a write request.
module set_mode_controller #(
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       wr_ack,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       wr_req,
  output logic       busy
);

  localparam int unsigned MAXV =
    (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW = $clog2(MAXV + 2);

  localparam int B_PROG  = 0;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 2;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 4;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    WRITE
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    btn_raw;
  logic [4:0]    btn_q, btn_d;
  logic [4:0]    prev_q, prev_d;
  logic          arm_q, arm_d;
  logic [4:0]    edge_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          per_q, per_d;
  logic [3:0]    en_q, en_d;
  logic          up_q, up_d;
  logic          dn_q, dn_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] lim;
  logic          up_h, dn_h;
  logic          fld_chg;

  assign btn_raw = {btn_down, btn_up, btn_right, btn_left, btn_prog};

  // First clock after reset loads both stages alike, so a held button is no edge.
  always_comb begin
    btn_d  = btn_raw;
    prev_d = arm_q ? btn_q : btn_raw;
    arm_d  = 1'b1;
  end

  assign edge_w = btn_q & ~prev_q;
  assign up_h   = btn_q[B_UP];
  assign dn_h   = btn_q[B_DOWN];
  assign lim    = per_q ? CW'(REPEAT_PER) : CW'(REPEAT_DLY);
  assign fld_chg = edge_w[B_LEFT] ^ edge_w[B_RIGHT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    en_d    = en_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wr_d    = wr_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        en_d   = 4'd0;
        cnt_d  = '0;
        per_d  = 1'b0;
        wr_d   = 1'b0;
        busy_d = 1'b0;
        if (edge_w[B_PROG]) begin
          state_d = EDIT;
          en_d    = 4'd1;
          busy_d  = 1'b1;
        end
      end
      EDIT: begin
        busy_d = 1'b1;
        if (edge_w[B_PROG]) begin
          state_d = WRITE;
          en_d    = 4'd0;
          wr_d    = 1'b1;
          cnt_d   = '0;
          per_d   = 1'b0;
        end else begin
          if (edge_w[B_RIGHT] && !edge_w[B_LEFT])
            en_d = (en_q == 4'd6) ? 4'd1 : en_q + 4'd1;
          else if (edge_w[B_LEFT] && !edge_w[B_RIGHT])
            en_d = (en_q == 4'd1) ? 4'd6 : en_q - 4'd1;
          if (up_h ^ dn_h) begin
            if (edge_w[B_UP] || edge_w[B_DOWN]) begin
              up_d  = edge_w[B_UP];
              dn_d  = edge_w[B_DOWN];
              cnt_d = CW'(1);
              per_d = 1'b0;
            end else if (cnt_q == '0) begin
              cnt_d = CW'(1);
              per_d = 1'b0;
            end else if (cnt_q >= lim) begin
              up_d  = up_h;
              dn_d  = dn_h;
              cnt_d = CW'(1);
              per_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
            per_d = 1'b0;
          end
          if (fld_chg) begin
            cnt_d = '0;
            per_d = 1'b0;
          end
        end
      end
      WRITE: begin
        en_d   = 4'd0;
        wr_d   = 1'b1;
        busy_d = 1'b1;
        cnt_d  = '0;
        per_d  = 1'b0;
        if (wr_ack) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 4'd0;
        cnt_d   = '0;
        per_d   = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      btn_q   <= '0;
      prev_q  <= '0;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      per_q   <= 1'b0;
      en_q    <= 4'd0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      en_q    <= en_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign en_count = en_q;
  assign enUP     = up_q;
  assign enDOWN   = dn_q;
  assign wr_req   = wr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_set_mode_controller.sv
// Directed bench for set_mode_controller with short repeat timing.
// Each step compares the outputs against hand-derived values.
module tb_set_mode_controller;

  logic       clk;
  logic       reset;
  logic [4:0] b;
  logic       wr_ack;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       wr_req;
  logic       busy;

  int checks;
  int failures;

  set_mode_controller #(
    .REPEAT_DLY(20),
    .REPEAT_PER(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_prog (b[0]),
    .btn_left (b[1]),
    .btn_right(b[2]),
    .btn_up   (b[3]),
    .btn_down (b[4]),
    .wr_ack   (wr_ack),
    .en_count (en_count),
    .enUP     (enUP),
    .enDOWN   (enDOWN),
    .wr_req   (wr_req),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press; returns once the resulting state change is visible.
  task automatic press(input logic [4:0] m);
    b = b | m;
    @(negedge clk);
    b = b & ~m;
    @(negedge clk);
  endtask

  logic [63:0] umask;
  logic [63:0] dmask;
  logic [63:0] exp_mask;
  logic [3:0]  exp_seq [7];

  initial begin
    checks   = 0;
    failures = 0;
    b        = '0;
    wr_ack   = 1'b0;
    reset    = 1'b1;
    exp_seq  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd2};
    step(3);
    chk("rst_en", en_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr_req, 0);
    chk("rst_pulse", {enUP, enDOWN}, 0);
    reset = 1'b0;
    step(2);

    press(5'b01000);
    chk("idle_up_ignored", {enUP, enDOWN, busy}, 0);

    press(5'b00001);
    chk("edit_busy", busy, 1);
    chk("edit_en", en_count, 1);
    for (int i = 0; i < 7; i++) begin
      press(5'b00100);
      chk($sformatf("right_%0d", i), en_count, exp_seq[i]);
    end
    press(5'b00010);
    chk("left_2to1", en_count, 1);
    press(5'b00010);
    chk("left_wrap", en_count, 6);
    press(5'b00100);
    press(5'b00100);
    press(5'b00100);
    chk("en3", en_count, 3);
    press(5'b00110);
    chk("left_right_same", en_count, 3);
    press(5'b00100);
    chk("en4", en_count, 4);

    // Held up: pulses at k=2, then +20, then every 5 while held.
    umask = '0;
    dmask = '0;
    b[3]  = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      umask[k] = enUP;
      dmask[k] = enDOWN;
      if (k == 35) b[3] = 1'b0;
    end
    exp_mask = '0;
    exp_mask[2]  = 1'b1;
    exp_mask[22] = 1'b1;
    exp_mask[27] = 1'b1;
    exp_mask[32] = 1'b1;
    chk("up_repeat_mask", umask, exp_mask);
    chk("up_no_down", dmask, 0);

    umask = '0;
    dmask = '0;
    b[4]  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      umask[k] = enUP;
      dmask[k] = enDOWN;
      if (k == 1) b[4] = 1'b0;
    end
    exp_mask = '0;
    exp_mask[2] = 1'b1;
    chk("down_single", dmask, exp_mask);
    chk("down_no_up", umask, 0);

    // Both held: silence; dropping down restarts the delay.
    umask = '0;
    dmask = '0;
    b[3]  = 1'b1;
    b[4]  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      umask[k] = enUP;
      dmask[k] = enDOWN;
    end
    chk("both_held_none", {umask, dmask} != 0, 0);
    umask = '0;
    dmask = '0;
    b[4]  = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      umask[k] = enUP;
      dmask[k] = enDOWN;
    end
    b[3] = 1'b0;
    exp_mask = '0;
    exp_mask[22] = 1'b1;
    chk("restart_up_mask", umask, exp_mask);
    chk("restart_no_down", dmask, 0);
    step(3);

    press(5'b00001);
    chk("write_en", en_count, 0);
    chk("write_req", wr_req, 1);
    chk("write_busy", busy, 1);
    chk("write_no_pulse", {enUP, enDOWN}, 0);
    press(5'b00100);
    press(5'b01000);
    press(5'b00001);
    step(4);
    chk("write_ignore", {en_count, enUP, wr_req, busy}, {4'd0, 3'b011});
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("ack_wr", wr_req, 0);
    chk("ack_busy", busy, 0);
    step(2);
    chk("ack_idle_en", en_count, 0);

    press(5'b00001);
    press(5'b00100);
    chk("re_edit_en", en_count, 2);
    press(5'b00001);
    chk("re_write_req", wr_req, 1);
    b[0] = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst", {en_count, enUP, enDOWN, wr_req, busy}, 0);
    step(2);
    reset = 1'b0;
    step(5);
    chk("held_prog_idle", {busy, en_count, wr_req}, 0);
    b[0] = 1'b0;
    step(1);
    press(5'b00001);
    chk("repress_edit", {busy, en_count}, {1'b1, 4'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
